// File: rtl/cache_pkg.sv
// Shared encodings for the cache arbiter: FSM states, grant identifiers and
// the bundled request fields forwarded to the bridge.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_ADDR = 3'd1,
    I_DATA = 3'd2,
    D_ADDR = 3'd3,
    D_DATA = 3'd4
  } arb_state_e;

  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } grant_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/cache_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; the last grant is remembered only when the
// caller commits a grant, so ties alternate between the two masters.
module rr_arb2
  import cache_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_req_inst,
  input  logic   i_req_data,
  input  logic   i_update,
  output logic   o_valid,
  output grant_e o_grant
);

  grant_e r_last_grant;

  // Reset to DATA so the instruction side wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= GRANT_DATA;
    end else if (i_update) begin
      r_last_grant <= o_grant;
    end
  end

  always_comb begin
    o_valid = i_req_inst | i_req_data;
    o_grant = GRANT_INST;
    if (i_req_inst && i_req_data) begin
      if (r_last_grant == GRANT_INST) begin
        o_grant = GRANT_DATA;
      end else begin
        o_grant = GRANT_INST;
      end
    end else if (i_req_data) begin
      o_grant = GRANT_DATA;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Serialises the instruction and data cache sram-like masters onto a single
// bridge port with at most one transaction outstanding.
//
// state  | meaning
// IDLE   | no transaction; arbitrate among pending requests
// I_ADDR | inst request presented to bridge, waiting for addr_ok
// I_DATA | inst request accepted, waiting for data_ok
// D_ADDR | data request presented to bridge, waiting for addr_ok
// D_DATA | data request accepted, waiting for data_ok
module cache_arbiter
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic        out_req,
  output logic        out_wr,
  output logic [1:0]  out_size,
  output logic [31:0] out_addr,
  output logic [31:0] out_wdata,
  input  logic [31:0] out_rdata,
  input  logic        out_addr_ok,
  input  logic        out_data_ok
);

  arb_state_e r_state;
  arb_state_e w_next;
  logic       w_arb_valid;
  grant_e     w_arb_grant;
  logic       w_arb_update;
  sram_req_t  w_inst;
  sram_req_t  w_data;
  sram_req_t  w_out;

  assign w_inst = {inst_wr, inst_size, inst_addr, inst_wdata};
  assign w_data = {data_wr, data_size, data_addr, data_wdata};

  rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .rst        (rst),
    .i_req_inst (inst_req),
    .i_req_data (data_req),
    .i_update   (w_arb_update),
    .o_valid    (w_arb_valid),
    .o_grant    (w_arb_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_arb_update = 1'b0;
    w_out        = '0;
    out_req      = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arb_valid) begin
          w_arb_update = 1'b1;
          if (w_arb_grant == GRANT_INST) begin
            w_next = I_ADDR;
          end else begin
            w_next = D_ADDR;
          end
        end
      end
      I_ADDR: begin
        out_req      = 1'b1;
        w_out        = w_inst;
        inst_addr_ok = out_addr_ok;
        // A bridge may accept and return in the same cycle; skip I_DATA then.
        inst_data_ok = out_addr_ok & out_data_ok;
        if (out_addr_ok) begin
          w_next = out_data_ok ? IDLE : I_DATA;
        end
      end
      I_DATA: begin
        inst_data_ok = out_data_ok;
        if (out_data_ok) begin
          w_next = IDLE;
        end
      end
      D_ADDR: begin
        out_req      = 1'b1;
        w_out        = w_data;
        data_addr_ok = out_addr_ok;
        data_data_ok = out_addr_ok & out_data_ok;
        if (out_addr_ok) begin
          w_next = out_data_ok ? IDLE : D_DATA;
        end
      end
      D_DATA: begin
        data_data_ok = out_data_ok;
        if (out_data_ok) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign out_wr     = w_out.wr;
  assign out_size   = w_out.size;
  assign out_addr   = w_out.addr;
  assign out_wdata  = w_out.wdata;

  // Read data is shared; each master qualifies it with its own data_ok.
  assign inst_rdata = out_rdata;
  assign data_rdata = out_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed and randomized checks of cache_arbiter against a transaction-level
// model of the arbitration and handshake rules.
module tb_cache_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic        out_req, out_wr;
  logic [1:0]  out_size;
  logic [31:0] out_addr, out_wdata, out_rdata;
  logic        out_addr_ok, out_data_ok;

  int unsigned checks;
  int unsigned errors;

  cache_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_rdata   (inst_rdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_rdata   (data_rdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .out_req      (out_req),
    .out_wr       (out_wr),
    .out_size     (out_size),
    .out_addr     (out_addr),
    .out_wdata    (out_wdata),
    .out_rdata    (out_rdata),
    .out_addr_ok  (out_addr_ok),
    .out_data_ok  (out_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic e_req, input logic e_wr,
                             input logic [1:0] e_size, input logic [31:0] e_addr,
                             input logic [31:0] e_wdata, input logic e_iaok,
                             input logic e_idok, input logic e_daok, input logic e_ddok);
    chk({tag, ".out_req"}, out_req, e_req);
    chk({tag, ".out_wr"}, out_wr, e_wr);
    chk({tag, ".out_size"}, out_size, e_size);
    chk({tag, ".out_addr"}, out_addr, e_addr);
    chk({tag, ".out_wdata"}, out_wdata, e_wdata);
    chk({tag, ".inst_addr_ok"}, inst_addr_ok, e_iaok);
    chk({tag, ".inst_data_ok"}, inst_data_ok, e_idok);
    chk({tag, ".data_addr_ok"}, data_addr_ok, e_daok);
    chk({tag, ".data_data_ok"}, data_data_ok, e_ddok);
  endtask

  // Drive bridge responses for the coming cycle, then settle before sampling.
  task automatic cyc(input logic aok, input logic dok, input logic [31:0] rd);
    @(negedge clk);
    out_addr_ok = aok;
    out_data_ok = dok;
    out_rdata   = rd;
    #1;
  endtask

  task automatic clear_masters();
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = '0; inst_wdata = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = '0; data_wdata = '0;
  endtask

  task automatic do_reset();
    clear_masters();
    out_addr_ok = 1'b0; out_data_ok = 1'b0; out_rdata = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Random-phase model state: phase 0 idle, 1 address, 2 data.
  bit          ip, dp;
  bit          iwr, dwr;
  logic [1:0]  isz, dsz;
  logic [31:0] iad, dad, iwd, dwd;
  int          m_phase;
  bit          m_owner;
  bit          m_last;
  bit          was_idle;
  int          completions;
  int          b_aw, b_dw;
  bit          aok, dok;
  logic [31:0] rd;
  logic        e_req, e_wr;
  logic [1:0]  e_size;
  logic [31:0] e_addr, e_wdata;
  int          last_req, n_dok, n_req;
  bit          pend;

  initial begin
    checks = 0;
    errors = 0;

    // Reset state
    do_reset();
    cyc(1'b0, 1'b0, 32'h0);
    expect_outs("reset", 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0);
    chk("reset.inst_rdata", inst_rdata, 32'h0);

    // Single instruction read with delayed bridge handshakes
    inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'hBFC0_0000;
    cyc(1'b0, 1'b0, 32'h0);
    expect_outs("ird.wait1", 1, 0, 2'd2, 32'hBFC0_0000, 32'h0, 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 32'h0);
    expect_outs("ird.wait2", 1, 0, 2'd2, 32'hBFC0_0000, 32'h0, 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 32'h0);
    expect_outs("ird.accept", 1, 0, 2'd2, 32'hBFC0_0000, 32'h0, 1, 0, 0, 0);
    clear_masters();
    cyc(1'b0, 1'b0, 32'h0);
    expect_outs("ird.data1", 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 32'h0);
    expect_outs("ird.data2", 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0);
    cyc(1'b0, 1'b1, 32'h2408_0001);
    expect_outs("ird.done", 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 0, 0);
    chk("ird.inst_rdata", inst_rdata, 32'h2408_0001);
    cyc(1'b0, 1'b0, 32'h0);
    expect_outs("ird.idle", 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0);

    // Simultaneous requests alternate: inst, data, inst
    do_reset();
    inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'h1000_0000;
    data_req = 1'b1; data_size = 2'd2; data_addr = 32'h2000_0000;
    cyc(1'b1, 1'b0, 32'h0);
    expect_outs("rr.first_inst", 1, 0, 2'd2, 32'h1000_0000, 32'h0, 1, 0, 0, 0);
    inst_addr = 32'h1000_0004;
    cyc(1'b0, 1'b1, 32'h55);
    expect_outs("rr.inst_data", 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 0, 0);
    cyc(1'b0, 1'b0, 32'h0);
    expect_outs("rr.gap1", 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 32'h0);
    expect_outs("rr.then_data", 1, 0, 2'd2, 32'h2000_0000, 32'h0, 0, 0, 1, 0);
    data_addr = 32'h2000_0004;
    cyc(1'b0, 1'b1, 32'h66);
    expect_outs("rr.data_data", 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 1);
    cyc(1'b0, 1'b0, 32'h0);
    expect_outs("rr.gap2", 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0);
    cyc(1'b1, 1'b1, 32'h77);
    expect_outs("rr.inst_again", 1, 0, 2'd2, 32'h1000_0004, 32'h0, 1, 1, 0, 0);
    clear_masters();
    cyc(1'b0, 1'b0, 32'h0);
    expect_outs("rr.idle", 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0);

    // Data write forwarding
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_addr = 32'h8000_0010; data_wdata = 32'hDEAD_BEEF;
    cyc(1'b0, 1'b0, 32'h0);
    expect_outs("dwr.present", 1, 1, 2'd2, 32'h8000_0010, 32'hDEAD_BEEF, 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 32'h0);
    expect_outs("dwr.accept", 1, 1, 2'd2, 32'h8000_0010, 32'hDEAD_BEEF, 0, 0, 1, 0);
    clear_masters();
    cyc(1'b0, 1'b0, 32'h0);
    expect_outs("dwr.wait", 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0);
    cyc(1'b0, 1'b1, 32'h0);
    expect_outs("dwr.done", 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 1);
    cyc(1'b0, 1'b0, 32'h0);
    expect_outs("dwr.idle", 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0);

    // addr_ok and data_ok together in I_ADDR return straight to IDLE
    inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'h0000_0100;
    cyc(1'b0, 1'b0, 32'h0);
    expect_outs("same.present", 1, 0, 2'd2, 32'h0000_0100, 32'h0, 0, 0, 0, 0);
    cyc(1'b1, 1'b1, 32'hCAFE_0001);
    expect_outs("same.both", 1, 0, 2'd2, 32'h0000_0100, 32'h0, 1, 1, 0, 0);
    chk("same.inst_rdata", inst_rdata, 32'hCAFE_0001);
    inst_addr = 32'h0000_0200;
    cyc(1'b0, 1'b0, 32'h0);
    expect_outs("same.idle", 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0);
    cyc(1'b1, 1'b1, 32'h0);
    expect_outs("same.next", 1, 0, 2'd2, 32'h0000_0200, 32'h0, 1, 1, 0, 0);
    clear_masters();
    cyc(1'b0, 1'b0, 32'h0);

    // Reset while in D_DATA abandons the transaction
    data_req = 1'b1; data_size = 2'd2; data_addr = 32'h8000_0020;
    cyc(1'b1, 1'b0, 32'h0);
    expect_outs("rst.accept", 1, 0, 2'd2, 32'h8000_0020, 32'h0, 0, 0, 1, 0);
    clear_masters();
    cyc(1'b0, 1'b0, 32'h0);
    expect_outs("rst.in_data", 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 32'h0);
    expect_outs("rst.abandon", 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0);
    rst = 1'b0;
    inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'hBFC0_0004;
    cyc(1'b1, 1'b0, 32'h0);
    expect_outs("rst.fresh", 1, 0, 2'd2, 32'hBFC0_0004, 32'h0, 1, 0, 0, 0);
    clear_masters();
    cyc(1'b0, 1'b1, 32'h0000_1234);
    expect_outs("rst.fresh_done", 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 0, 0);
    chk("rst.inst_rdata", inst_rdata, 32'h0000_1234);
    cyc(1'b0, 1'b0, 32'h0);

    // Continuous inst requests with a zero-latency bridge: one per 3 cycles
    inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'h0000_1000;
    pend = 1'b0; n_dok = 0; n_req = 0; last_req = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      out_addr_ok = out_req;
      out_data_ok = pend;
      out_rdata   = 32'(k);
      #1;
      if (out_req) begin
        if (last_req >= 0) chk("b2b.spacing", 32'(k - last_req), 32'd3);
        last_req = k;
        n_req++;
      end
      if (inst_data_ok) n_dok++;
      pend = out_req;
    end
    chk("b2b.req_count", 32'(n_req), 32'd6);
    chk("b2b.dok_count", 32'(n_dok), 32'd5);
    clear_masters();
    cyc(1'b0, 1'b1, 32'h0);
    chk("b2b.last_dok", inst_data_ok, 1'b1);
    cyc(1'b0, 1'b0, 32'h0);

    // Randomized traffic against the transaction-level model
    do_reset();
    ip = 0; dp = 0; m_phase = 0; m_owner = 0; m_last = 1'b1;
    completions = 0; b_aw = -1; b_dw = -1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      aok = 0; dok = 0;
      if (out_req) begin
        if (b_aw < 0) b_aw = $urandom_range(0, 2);
        if (b_aw == 0) begin
          aok = 1; b_aw = -1;
          if ($urandom_range(0, 3) == 0) dok = 1;
          else b_dw = $urandom_range(0, 3);
        end else begin
          b_aw--;
        end
      end else if (b_dw >= 0) begin
        if (b_dw == 0) begin dok = 1; b_dw = -1; end
        else b_dw--;
      end
      rd = $urandom;
      out_addr_ok = aok; out_data_ok = dok; out_rdata = rd;
      #1;

      e_req = (m_phase == 1);
      {e_wr, e_size, e_addr, e_wdata} = '0;
      if (m_phase == 1) begin
        if (m_owner) {e_wr, e_size, e_addr, e_wdata} = {dwr, dsz, dad, dwd};
        else         {e_wr, e_size, e_addr, e_wdata} = {iwr, isz, iad, iwd};
      end
      expect_outs("rand", e_req, e_wr, e_size, e_addr, e_wdata,
                  (m_phase == 1) && !m_owner && aok,
                  !m_owner && (((m_phase == 1) && aok && dok) || ((m_phase == 2) && dok)),
                  (m_phase == 1) && m_owner && aok,
                  m_owner && (((m_phase == 1) && aok && dok) || ((m_phase == 2) && dok)));
      chk("rand.inst_rdata", inst_rdata, rd);
      chk("rand.data_rdata", data_rdata, rd);

      was_idle = (m_phase == 0);
      if (m_phase == 1 && aok) begin
        if (m_owner) dp = 0; else ip = 0;
        if (dok) begin m_phase = 0; completions++; end
        else m_phase = 2;
      end else if (m_phase == 2 && dok) begin
        m_phase = 0;
        completions++;
      end
      if (!ip && $urandom_range(0, 1) == 1) begin
        ip = 1; iwr = 1'($urandom_range(0, 1)); isz = 2'($urandom_range(0, 2));
        iad = $urandom; iwd = $urandom;
      end
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1; dwr = 1'($urandom_range(0, 1)); dsz = 2'($urandom_range(0, 2));
        dad = $urandom; dwd = $urandom;
      end
      if (was_idle && (ip || dp)) begin
        if (ip && dp) m_owner = ~m_last;
        else m_owner = dp;
        m_last = m_owner;
        m_phase = 1;
      end
      inst_req = ip; inst_wr = iwr; inst_size = isz; inst_addr = iad; inst_wdata = iwd;
      data_req = dp; data_wr = dwr; data_size = dsz; data_addr = dad; data_wdata = dwd;
    end
    chk("rand.progress", 32'(completions >= 20), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
